decrement_counter: RTL



---
 rtl/decrement_counter.sv | 114 +++++++++++
 1 files changed

// File: rtl/decrement_counter.sv
// decrement_counter: loadable, pausable down-counter that sequences N
// iterations of a multiply step. A start/busy/done handshake launches,
// stalls, aborts and signals completion of a run. The decrement is a
// ripple half-subtractor borrow chain with a constant borrow-in of 1.
module decrement_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             hold,
    input  logic             abort,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;

    // Borrow chain: borrow[0] is the constant borrow-in that makes this a
    // decrement. The borrow out of the top stage is never needed because
    // RUN is never entered or held with count == 0, so it is not built.
    logic [WIDTH-1:0] borrow;
    logic [WIDTH-1:0] count_dec;
    logic             count_is_one;

    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_hsub
            // Half-subtractor stage: difference and borrow to the next bit.
            assign count_dec[gi] = count[gi] ^ borrow[gi];
            if (gi < WIDTH - 1) begin : g_chain
                assign borrow[gi+1] = ~count[gi] & borrow[gi];
            end
        end
    endgenerate

    assign count_is_one = (count == {{(WIDTH-1){1'b0}}, 1'b1});

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            tick  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tick <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        if (load_val == '0) begin
                            // Zero-length run completes without ever going busy.
                            count <= '0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            count <= load_val;
                            busy  <= 1'b1;
                            state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    done <= 1'b0;
                    if (abort) begin
                        // Abort wins over hold; count freezes where it is.
                        busy  <= 1'b0;
                        tick  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (hold) begin
                        tick <= 1'b0;
                    end else begin
                        count <= count_dec;
                        tick  <= 1'b1;
                        if (count_is_one) begin
                            // Last decrement: tick and done land together.
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // Single done cycle; start here is deliberately ignored.
                    tick  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    tick  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
